// File: rtl/imem_fetch.sv
// Instruction memory with a program-write port and a one-deep fetch response register.
// Latency 1 from accept to rsp_valid; a stalled response holds and blocks new requests.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module imem_fetch #(
    parameter int                    WORD_WIDTH = `WORD_WIDTH,
    parameter int                    ADDR_BITS  = 6,
    parameter bit                    BYTE_ADDR  = 1'b0,
    parameter logic [WORD_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_en,
    input  logic [ADDR_BITS-1:0]  prog_addr,
    input  logic [WORD_WIDTH-1:0] prog_data,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WORD_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_instr,
    output logic                  rsp_err,
    output logic [15:0]           fetch_count
);

    localparam int DEPTH     = 2 ** ADDR_BITS;
    localparam int IDX_LSB   = BYTE_ADDR ? 2 : 0;
    localparam int FIELD_TOP = ADDR_BITS + IDX_LSB;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      wr_flag_q;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [15:0]           fetch_count_q, fetch_count_d;

    logic [ADDR_BITS-1:0]  fetch_idx;
    logic [WORD_WIDTH-1:0] addr_hi;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  fetch_err;
    logic [WORD_WIDTH-1:0] fetch_word;
    logic                  accept;

    // Data words carry no reset; the written-flags alone decide whether a word is visible.
    always_ff @(posedge clk) begin
        if (prog_en) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_flag_q <= '0;
        end else if (prog_en) begin
            wr_flag_q[prog_addr] <= 1'b1;
        end
    end

    always_comb begin
        fetch_idx    = req_addr[IDX_LSB +: ADDR_BITS];
        addr_hi      = req_addr >> FIELD_TOP;
        out_of_range = |addr_hi;
        misaligned   = BYTE_ADDR && (req_addr[1:0] != 2'b00);
        fetch_err    = out_of_range || misaligned;
        if (fetch_err || !wr_flag_q[fetch_idx]) begin
            fetch_word = NOP_WORD;
        end else begin
            fetch_word = mem_q[fetch_idx];
        end
    end

    // A program write blocks fetches outright, so a same-word write/fetch cannot collide.
    assign req_ready = !prog_en && !flush && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_instr_d   = rsp_instr_q;
        rsp_err_d     = rsp_err_q;
        fetch_count_d = fetch_count_q;

        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_instr_d = fetch_word;
            rsp_err_d   = fetch_err;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (rsp_valid_q && rsp_ready) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_instr_q   <= NOP_WORD;
            rsp_err_q     <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_instr_q   <= rsp_instr_d;
            rsp_err_q     <= rsp_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_instr   = rsp_instr_q;
    assign rsp_err     = rsp_err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter WORD_WIDTH, default `WORD_WIDTH (32), SHALL set the instruction and program-data width.
REQ-002 Parameter ADDR_BITS, default 6, SHALL set the word-address width, giving DEPTH = 2**ADDR_BITS words.
REQ-003 Parameter BYTE_ADDR, default 0, SHALL select byte addressing (1: fetch word = addr[ADDR_BITS+1:2]) or word addressing (0: fetch word = addr[ADDR_BITS-1:0]).
REQ-004 Parameter NOP_WORD, default 32'h0000_0000, SHALL set the word returned for unwritten or erroring locations.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port prog_en, input, 1: program-write strobe.
REQ-008 Port prog_addr, input, ADDR_BITS: program-write word address.
REQ-009 Port prog_data, input, WORD_WIDTH: program-write data.
REQ-010 Port flush, input, 1: discards any held response.
REQ-011 Port req_valid, input, 1: fetch request present.
REQ-012 Port req_ready, output, 1: fetch request accepted this cycle when high together with req_valid.
REQ-013 Port req_addr, input, WORD_WIDTH: fetch address.
REQ-014 Port rsp_valid, output, 1: response held.
REQ-015 Port rsp_ready, input, 1: consumer accepts the response; low means stall.
REQ-016 Port rsp_instr, output, WORD_WIDTH: fetched instruction.
REQ-017 Port rsp_err, output, 1: response is an out-of-range or misaligned fetch.
REQ-018 Port fetch_count, output, 16: count of accepted responses.

Function
REQ-019 Storage SHALL be DEPTH x WORD_WIDTH words plus one written-flag per word.
REQ-020 When prog_en is high, prog_data SHALL be written to word prog_addr and its written-flag set at the clock edge.
REQ-021 req_ready SHALL equal !prog_en && !flush && (!rsp_valid || rsp_ready).
REQ-022 An accepted request SHALL produce rsp_valid=1 with its data exactly one cycle later (latency 1); back-to-back accepts SHALL sustain one response per cycle.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_instr and rsp_err SHALL hold stable and no request SHALL be accepted.
REQ-024 With rsp_valid=1, rsp_ready=1 and no new accept, rsp_valid SHALL fall on the next edge.
REQ-025 rsp_err SHALL be 1 when any req_addr bit above the fetch-word field is nonzero, or when BYTE_ADDR=1 and req_addr[1:0]!=0; rsp_instr SHALL then be NOP_WORD.
REQ-026 A fetch of a word whose written-flag is 0 SHALL return NOP_WORD with rsp_err=0.
REQ-027 On a write and a fetch of the same word in the same cycle, the write SHALL win and the fetch SHALL not be accepted (REQ-021).
REQ-028 flush SHALL clear rsp_valid at the next edge, with priority over any accept or hold.
REQ-029 fetch_count SHALL increment on each cycle with rsp_valid && rsp_ready and wrap from 16'hFFFF to 0.

Reset
REQ-030 rst high SHALL immediately force rsp_valid=0, rsp_instr=NOP_WORD, rsp_err=0, fetch_count=0 and all written-flags=0, independent of clk.
REQ-031 Memory data words SHALL NOT be reset; clearing the written-flags makes them read as NOP_WORD.
REQ-032 rst asserted mid-stall SHALL drop the held response, which SHALL never be delivered.

Verification
REQ-033 Write 32'h0022_0000 to word 0, then fetch addr 0 with rsp_ready=1 -> the next cycle has rsp_valid=1, rsp_instr=32'h0022_0000, rsp_err=0, and fetch_count becomes 1.
REQ-034 Fetch word 5 when it has never been written -> rsp_instr=NOP_WORD, rsp_err=0.
REQ-035 Set BYTE_ADDR=1 and fetch addr 6 -> rsp_err=1 and rsp_instr=NOP_WORD; fetch addr 256 with ADDR_BITS=6 -> rsp_err=1.
REQ-036 Hold rsp_ready=0 for 3 cycles while req_valid=1 -> req_ready=0 and rsp_instr is stable; release it -> one response per cycle resumes with no lost or duplicated fetch.
REQ-037 Assert flush during a stall -> rsp_valid=0 at the next edge and fetch_count is unchanged.
REQ-038 Write words 0..3, pulse rst asynchronously, then fetch word 2 -> NOP_WORD, with all outputs at their reset values during rst.
